// File: rtl/time_display_pkg.sv
// Shared types and seven-segment constants for the countdown display.
// Segment patterns are active-low with bit order gfedcba.
package time_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic logic [6:0] bcd2seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 7-bit binary to two-digit BCD converter (shift-add-3, 7 iterations).
// Inputs above 99 saturate to 99; only the latest differing input is converted.
module bin2bcd_seq
  import time_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       busy_o
);

  conv_state_e state_q, state_d;
  logic [6:0]  cap_raw_q, cap_raw_d;
  logic        first_q, first_d;
  logic [14:0] work_q, work_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [14:0] adj;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d   = state_q;
    cap_raw_d = cap_raw_q;
    first_d   = first_q;
    work_d    = work_q;
    bit_d     = bit_q;
    tens_d    = tens_q;
    ones_d    = ones_q;

    adj = work_q;
    if (work_q[14:11] >= 4'd5) adj[14:11] = work_q[14:11] + 4'd3;
    if (work_q[10:7]  >= 4'd5) adj[10:7]  = work_q[10:7]  + 4'd3;

    case (state_q)
      IDLE: begin
        if ((bin_i != cap_raw_q) || first_q) begin
          cap_raw_d = bin_i;
          first_d   = 1'b0;
          work_d    = {8'd0, (bin_i > 7'd99) ? 7'd99 : bin_i};
          bit_d     = 3'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        work_d = {adj[13:0], 1'b0};
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd6) state_d = COMMIT;
      end
      COMMIT: begin
        tens_d  = work_q[14:11];
        ones_d  = work_q[10:7];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cap_raw_q <= 7'd0;
      first_q   <= 1'b1;
      work_q    <= 15'd0;
      bit_q     <= 3'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      cap_raw_q <= cap_raw_d;
      first_q   <= first_d;
      work_q    <= work_d;
      bit_q     <= bit_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/time_display.sv
// Countdown display: BCD conversion plus multiplexed active-low 2-digit 7-seg drive.
// Define TIME_DISPLAY_BLINK_EN to flash the display while 0 < value < LOW_TIME.
module time_display
  import time_display_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2,
  parameter int LOW_TIME = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] counter,
  input  logic       en,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       busy,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int SCAN_DIV = CLK_HZ / (2 * SCAN_HZ);
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .bin_i (counter),
    .tens_o(bcd_tens),
    .ones_o(bcd_ones),
    .busy_o(busy)
  );

  logic [SCAN_W-1:0] scan_cnt_q;
  logic              digit_sel_q;
  logic              blank_blink;
  logic [6:0]        seg_q, seg_d;
  logic [1:0]        an_q, an_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      digit_sel_q <= 1'b0;
    end else if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_q  <= '0;
      digit_sel_q <= ~digit_sel_q;
    end else begin
      scan_cnt_q  <= scan_cnt_q + 1'b1;
    end
  end

`ifdef TIME_DISPLAY_BLINK_EN
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;
  logic [6:0]         value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + 1'b1;
    end
  end

  // Blink decision follows the committed digits, so it never flickers mid-conversion.
  assign value       = {3'd0, bcd_tens} * 7'd10 + {3'd0, bcd_ones};
  assign blank_blink = blink_phase_q && (value != 7'd0) && (int'(value) < LOW_TIME);
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^{BLINK_HZ, LOW_TIME};
  assign blank_blink      = 1'b0;
`endif

  always_comb begin
    seg_d = bcd2seg(digit_sel_q ? bcd_tens : bcd_ones);
    an_d  = ~(2'b01 << digit_sel_q);
    if (!en || blank_blink) begin
      seg_d = SEG_BLANK;
      an_d  = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      an_q  <= 2'b11;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_time_display.sv
// Directed self-checking bench for time_display with fast simulation clocks.
// Segment values below are hand-derived active-low gfedcba patterns.
module tb_time_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] counter = 7'd30;
  logic       en = 1'b1;
  logic [3:0] bcd_tens, bcd_ones;
  logic       busy;
  logic [6:0] seg;
  logic [1:0] an;

  int n_checks = 0;
  int n_pass   = 0;

  time_display #(
    .CLK_HZ  (1000),
    .SCAN_HZ (100),
    .BLINK_HZ(10),
    .LOW_TIME(10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .counter (counter),
    .en      (en),
    .bcd_tens(bcd_tens),
    .bcd_ones(bcd_ones),
    .busy    (busy),
    .seg     (seg),
    .an      (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_an(input logic [1:0] target, input string tag);
    int k = 0;
    while (an !== target && k < 40) begin
      tick();
      k++;
    end
    if (an !== target) check({tag, "_timeout"}, {30'd0, an}, {30'd0, target});
  endtask

  task automatic convert(input logic [6:0] val, input logic [3:0] et, input logic [3:0] eo,
                         input string tag);
    int b = 0;
    counter = val;
    repeat (20) begin
      tick();
      if (busy) b++;
    end
    check({tag, "_busy_cycles"}, b, 8);
    check({tag, "_tens"}, bcd_tens, et);
    check({tag, "_ones"}, bcd_ones, eo);
  endtask

  task automatic count_blank(input int cycles, output int blanks);
    blanks = 0;
    repeat (cycles) begin
      tick();
      if (an === 2'b11) blanks++;
    end
  endtask

  initial begin
    int b;
    int r;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_tens", bcd_tens, 0);
    check("rst_ones", bcd_ones, 0);
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 2'b11);

    // First pass after reset: busy for 8 edges, digits at edge 9
    rst_n = 1'b1;
    b = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy) b++;
    end
    check("first_busy_cycles", b, 8);
    tick();
    check("first_busy_done", busy, 0);
    check("first_tens", bcd_tens, 3);
    check("first_ones", bcd_ones, 0);
    tick(2);
    wait_an(2'b10, "scan_ones");
    check("seg_ones_0", seg, 7'h40);
    wait_an(2'b01, "scan_tens");
    check("seg_tens_3", seg, 7'h30);

    // Stepping countdown
    convert(7'd60, 4'd6, 4'd0, "step60");
    convert(7'd59, 4'd5, 4'd9, "step59");
    convert(7'd58, 4'd5, 4'd8, "step58");

    // Saturation
    convert(7'd127, 4'd9, 4'd9, "sat127");
    convert(7'd100, 4'd9, 4'd9, "sat100");

    // Input changes during conversion are ignored until IDLE
    counter = 7'd45;
    tick();
    check("mid_busy_start", busy, 1);
    tick(2);
    counter = 7'd44;
    tick(3);
    counter = 7'd43;
    tick(3);
    check("mid_commit_busy", busy, 0);
    check("mid_commit_tens", bcd_tens, 4);
    check("mid_commit_ones", bcd_ones, 5);
    b = 0;
    repeat (20) begin
      tick();
      if (busy) b++;
    end
    check("mid_second_busy", b, 8);
    check("mid_second_tens", bcd_tens, 4);
    check("mid_second_ones", bcd_ones, 3);

    // Low time
    counter = 7'd7;
    tick(12);
    check("low_tens", bcd_tens, 0);
    check("low_ones", bcd_ones, 7);
`ifdef TIME_DISPLAY_BLINK_EN
    r = 0;
    while (an === 2'b11 && r < 120) begin tick(); r++; end
    r = 0;
    while (an !== 2'b11 && r < 120) begin tick(); r++; end
    check("blink_find_blank", {30'd0, an}, 32'd3);
    r = 0;
    while (an === 2'b11 && r < 200) begin tick(); r++; end
    check("blink_blank_run", r, 50);
    r = 0;
    while (an !== 2'b11 && r < 200) begin tick(); r++; end
    check("blink_lit_run", r, 50);
`else
    count_blank(100, b);
    check("steady7_no_blank", b, 0);
    wait_an(2'b10, "steady7_ones");
    check("steady7_seg_ones", seg, 7'h78);
    wait_an(2'b01, "steady7_tens");
    check("steady7_seg_tens", seg, 7'h40);
`endif

    // Zero is steady "00"
    counter = 7'd0;
    tick(12);
    check("zero_tens", bcd_tens, 0);
    check("zero_ones", bcd_ones, 0);
    count_blank(120, b);
    check("zero_no_blank", b, 0);
    wait_an(2'b10, "zero_ones_scan");
    check("zero_seg_ones", seg, 7'h40);

    // Display disabled; conversion keeps going
    en = 1'b0;
    convert(7'd25, 4'd2, 4'd5, "en0");
    check("en0_seg", seg, 7'h7F);
    check("en0_an", an, 2'b11);
    count_blank(20, b);
    check("en0_all_blank", b, 20);
    en = 1'b1;

    // Asynchronous reset in the middle of SHIFT
    counter = 7'd80;
    tick(3);
    check("rst_mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_tens", bcd_tens, 0);
    check("rst_mid_ones", bcd_ones, 0);
    check("rst_mid_seg", seg, 7'h7F);
    check("rst_mid_an", an, 2'b11);
    rst_n = 1'b1;
    tick(12);
    check("rst_mid_reconv_tens", bcd_tens, 8);
    check("rst_mid_reconv_ones", bcd_ones, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
